bk_add_stage: RTL and testbench

BK_ADD_STAGE -- requirements
Module: bk_add_stage

---
 rtl/bk_pkg.sv | 26 ++
 rtl/bk_res_fifo.sv | 77 +++++++
 rtl/bk_add_stage.sv | 111 +++++++++++
 tb/tb_bk_add_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// ---------------------------------------------------------------------------
// bk_pkg
//   Shared widths and helpers for the Brent-Kung adder wrapper stage.
//   OP_W  : operand width fed to the 12-bit adder
//   SUM_W : adder result width (bit OP_W is carry-out)
//   BUS_W : width of the bit-interleaved operand bus
//   interleave() : packs A/B so that bus[2i] = A[i], bus[2i+1] = B[i]
// ---------------------------------------------------------------------------
package bk_pkg;

    localparam int OP_W  = 12;
    localparam int SUM_W = 13;
    localparam int BUS_W = 24;

    function automatic logic [BUS_W-1:0] interleave(input logic [OP_W-1:0] a,
                                                    input logic [OP_W-1:0] b);
        logic [BUS_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < OP_W; i++) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bk_res_fifo.sv
// ---------------------------------------------------------------------------
// bk_res_fifo
//   Small circular result FIFO. Pointers wrap modulo DEPTH; storage is not
//   reset, only the pointers and occupancy count are.
//   clk, rst_n : clock, async active-low reset
//   push/wdata : write request and data
//   pop/rdata  : read request and head-of-queue data
//   count      : current occupancy (0..DEPTH)
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module bk_res_fifo #(
    parameter int DEPTH = 3,
    parameter int SUM_W = 13
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [SUM_W-1:0]             wdata,
    input  logic                         pop,
    output logic [SUM_W-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [SUM_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             wr_en, rd_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    // A write while full is only accepted if the head leaves on the same edge.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/bk_add_stage.sv
// ---------------------------------------------------------------------------
// bk_add_stage
//   Registers an operand pair, presents it bit-interleaved to an external
//   combinational Brent-Kung adder, and buffers the returned sums in a FIFO.
//   Also keeps a saturating count of results that produced a carry-out.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (in_ready from registered state)
//   in_a, in_b          : 12-bit operands
//   add_inputs          : interleaved operand bus to the adder
//   add_outs            : 13-bit sum back from the adder
//   out_valid/out_ready : result handshake, out_sum is FIFO head
//   cnt_clr             : synchronous clear of carry_cnt (wins over increment)
//   carry_cnt           : saturating carry-out counter
// ---------------------------------------------------------------------------
module bk_add_stage
    import bk_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic [BUS_W-1:0]  add_inputs,
    input  logic [SUM_W-1:0]  add_outs,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  carry_cnt
);

    localparam int FCNT_W = $clog2(DEPTH + 1);

    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic              s1_valid_q, s1_valid_d;
    logic              rdy_en_q;
    logic [CNT_W-1:0]  carry_cnt_q, carry_cnt_d;

    logic              accept, push, pop;
    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_full, fifo_empty;
    logic [FCNT_W:0]   occupancy;

    assign accept = in_valid & in_ready;
    assign push   = s1_valid_q;
    assign pop    = out_valid & out_ready;

    // Occupancy counts the result still in the operand stage, so a slot is
    // always reserved for it and the FIFO cannot overflow. rdy_en_q holds
    // in_ready low until the first edge after reset release.
    assign occupancy = {1'b0, fifo_count} + (FCNT_W + 1)'(s1_valid_q);
    assign in_ready  = rdy_en_q & ~fifo_full & (occupancy < (FCNT_W + 1)'(DEPTH));

    assign add_inputs = interleave(a_q, b_q);
    assign out_valid  = ~fifo_empty;
    assign carry_cnt  = carry_cnt_q;

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        s1_valid_d  = accept;
        carry_cnt_d = carry_cnt_q;
        if (accept) begin
            a_d = in_a;
            b_d = in_b;
        end
        if (cnt_clr) begin
            carry_cnt_d = '0;
        end else if (push && add_outs[SUM_W-1] && (carry_cnt_q != '1)) begin
            carry_cnt_d = carry_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            rdy_en_q    <= 1'b0;
            carry_cnt_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            rdy_en_q    <= 1'b1;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    bk_res_fifo #(
        .DEPTH (DEPTH),
        .SUM_W (SUM_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (add_outs),
        .pop   (pop),
        .rdata (out_sum),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_bk_add_stage.sv
module tb_bk_add_stage;

    localparam int DEPTH = 3;
    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_a, in_b;
    logic [23:0] add_inputs;
    logic [12:0] add_outs;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_sum;
    logic        cnt_clr;
    logic [7:0]  carry_cnt;

    always #5 clk = ~clk;

    bk_add_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .add_inputs (add_inputs),
        .add_outs   (add_outs),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .cnt_clr    (cnt_clr),
        .carry_cnt  (carry_cnt)
    );

    // Behavioural stand-in for the external adder: de-interleave and add.
    logic [11:0] ma, mb;
    always_comb begin
        ma = '0;
        mb = '0;
        for (int i = 0; i < 12; i++) begin
            ma[i] = add_inputs[2*i];
            mb[i] = add_inputs[2*i+1];
        end
    end
    assign add_outs = {1'b0, ma} + {1'b0, mb};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Streams n carry-producing pairs with out_ready high, then lets the pipe drain.
    task automatic send_carries(input int n);
        int acc;
        acc = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < n + 20 && acc < n; cyc++) begin
            in_valid = 1'b1;
            in_a = 12'hFFF;
            in_b = 12'h001;
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        check("carry_accepts", acc, n);
    endtask

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [12:0] sum;
        logic [23:0] bus;
        logic        cy;
    } vec_t;

    vec_t        vecs[7];
    logic [12:0] expq[$];
    logic [12:0] held;
    logic [7:0]  cnt_before;

    initial begin
        vecs[0] = '{12'hFFF, 12'h001, 13'h1000, 24'h555557, 1'b1};
        vecs[1] = '{12'hAAA, 12'h555, 13'h0FFF, 24'h666666, 1'b0};
        vecs[2] = '{12'h000, 12'h000, 13'h0000, 24'h000000, 1'b0};
        vecs[3] = '{12'hFFF, 12'hFFF, 13'h1FFE, 24'hFFFFFF, 1'b1};
        vecs[4] = '{12'h800, 12'h800, 13'h1000, 24'hC00000, 1'b1};
        vecs[5] = '{12'h001, 12'h000, 13'h0001, 24'h000001, 1'b0};
        vecs[6] = '{12'h000, 12'h001, 13'h0001, 24'h000002, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b1; cnt_clr = 1'b0;

        // Reset state
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_carry_cnt", carry_cnt, 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_before_edge", in_ready, 0);
        step();
        check("rel_in_ready_after_edge", in_ready, 1);

        // Directed vectors: interleave, latency, sum, carry count
        foreach (vecs[k]) begin
            cnt_before = carry_cnt;
            in_valid = 1'b1;
            in_a = vecs[k].a;
            in_b = vecs[k].b;
            check("vec_in_ready", in_ready, 1);
            step();
            in_valid = 1'b0;
            in_a = ~vecs[k].a;
            in_b = ~vecs[k].b;
            check("vec_bus", add_inputs, vecs[k].bus);
            check("vec_not_yet_valid", out_valid, 0);
            step();
            check("vec_out_valid", out_valid, 1);
            check("vec_sum", out_sum, vecs[k].sum);
            check("vec_carry_cnt", carry_cnt, 32'(cnt_before) + 32'(vecs[k].cy));
            step();
            check("vec_popped", out_valid, 0);
        end

        // Back-to-back random stream
        begin
            int sent, got, first, last;
            logic [11:0] ra, rb;
            sent = 0; got = 0; first = -1; last = -1;
            expq.delete();
            out_ready = 1'b1;
            for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
                if (out_valid) begin
                    if (expq.size() > 0) check("stream_sum", out_sum, expq.pop_front());
                    else check("stream_unexpected_valid", out_valid, 0);
                    if (first < 0) first = cyc;
                    last = cyc;
                    got++;
                end
                if (sent < 10) begin
                    ra = 12'($urandom_range(4095));
                    rb = 12'($urandom_range(4095));
                    in_valid = 1'b1;
                    in_a = ra;
                    in_b = rb;
                    check("stream_in_ready", in_ready, 1);
                    expq.push_back({1'b0, ra} + {1'b0, rb});
                    sent++;
                end else begin
                    in_valid = 1'b0;
                end
                step();
            end
            in_valid = 1'b0;
            check("stream_count", got, 10);
            check("stream_one_per_cycle", last - first, 9);
        end

        // Backpressure: fill, hold, drain in order
        begin
            int acc;
            acc = 0;
            expq.delete();
            step();
            out_ready = 1'b0;
            for (int cyc = 0; cyc < 6; cyc++) begin
                in_valid = 1'b1;
                in_a = 12'(cyc * 100 + 7);
                in_b = 12'(cyc * 3 + 2);
                if (in_ready) begin
                    acc++;
                    expq.push_back({1'b0, in_a} + {1'b0, in_b});
                end
                step();
            end
            in_valid = 1'b0;
            check("bp_accepts", acc, DEPTH);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_head", out_sum, expq[0]);
            held = out_sum;
            step();
            step();
            step();
            check("bp_hold", out_sum, held);
            out_ready = 1'b1;
            for (int cyc = 0; cyc < 10 && expq.size() > 0; cyc++) begin
                if (out_valid) check("bp_drain_sum", out_sum, expq.pop_front());
                step();
            end
            check("bp_drained", expq.size(), 0);
            check("bp_empty_after", out_valid, 0);
        end

        // Carry counter: clear vs coincident push, saturation
        do_reset();
        check("cc_reset", carry_cnt, 0);
        send_carries(5);
        check("cc_five", carry_cnt, 5);
        in_valid = 1'b1;
        in_a = 12'hFFF;
        in_b = 12'h001;
        step();
        in_valid = 1'b0;
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("cc_clear_wins", carry_cnt, 0);
        step();
        check("cc_clear_stays", carry_cnt, 0);
        send_carries(255);
        check("cc_255", carry_cnt, 255);
        send_carries(1);
        check("cc_saturate", carry_cnt, 255);

        // Reset with buffered results and one in flight
        do_reset();
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            in_valid = 1'b1;
            in_a = 12'h111;
            in_b = 12'h222;
            step();
        end
        in_valid = 1'b0;
        check("mr_buffered", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid_immediate", out_valid, 0);
        check("mr_in_ready_immediate", in_ready, 0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        begin
            int stale;
            stale = 0;
            for (int cyc = 0; cyc < 5; cyc++) begin
                step();
                if (out_valid) stale++;
            end
            check("mr_no_stale", stale, 0);
        end
        in_valid = 1'b1;
        in_a = 12'h123;
        in_b = 12'h456;
        step();
        in_valid = 1'b0;
        step();
        check("mr_new_valid", out_valid, 1);
        check("mr_new_sum", out_sum, 13'h0579);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
